// File: rtl/t48_int_vec.sv
// t48_int_vec: multi-source interrupt controller for the T48 core.
// NUM_EXT active-low external sources (edge or level) plus the timer source,
// fixed priority ext0 > ext1 > ... > timer, with a per-source service vector
// and the pending/in-progress handshake towards the decoder.
module t48_int_vec #(
  parameter int unsigned NUM_EXT     = 2,
  parameter logic [6:0]  EDGE_MASK   = 7'b0000000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDX_W       = 3
) (
  input  logic               clk_i,
  input  logic               res_i,
  input  logic               en_clk_i,
  input  logic [2:0]         clk_mstate_i,
  input  logic               last_cycle_i,
  input  logic [NUM_EXT-1:0] int_n_i,
  input  logic               en_i_i,
  input  logic               dis_i_i,
  input  logic               en_tcnti_i,
  input  logic               dis_tcnti_i,
  input  logic               tim_overflow_i,
  input  logic               jtf_executed_i,
  input  logic               int_executed_i,
  input  logic               retr_executed_i,
  input  logic               mask_wr_i,
  input  logic [NUM_EXT-1:0] mask_i,
  output logic               tf_o,
  output logic               int_pending_o,
  output logic               int_in_progress_o,
  output logic [IDX_W-1:0]   int_src_o,
  output logic [11:0]        int_vec_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PEND   = 2'd1,
    ACTIVE = 2'd2
  } int_state_e;

  localparam logic [NUM_EXT-1:0] EDGE = EDGE_MASK[NUM_EXT-1:0];

  logic [NUM_EXT-1:0] sync_q [SYNC_STAGES];
  logic [NUM_EXT-1:0] s;
  logic [NUM_EXT-1:0] s_next;
  logic [NUM_EXT-1:0] fall;

  logic [NUM_EXT-1:0] edge_flag_q, edge_flag_d;
  logic [NUM_EXT-1:0] mask_q, mask_d;
  logic               int_enable_q, int_enable_d;
  logic               tim_en_q, tim_en_d;
  logic               tf_q, tf_d;
  logic               tim_pend_q, tim_pend_d;
  logic               in_progress_q, in_progress_d;
  logic [IDX_W-1:0]   int_src_q, int_src_d;
  int_state_e         state_q, state_d;

  logic [NUM_EXT-1:0] ext_req;
  logic [NUM_EXT-1:0] ack_vec;
  logic               ack;
  logic               any_req;
  logic [IDX_W-1:0]   win;

  // Input synchroniser, runs every clock regardless of the machine-state enable
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
    end else begin
      sync_q[0] <= int_n_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A falling edge is seen when the last stage is still high and the value about to enter it is low
  assign s      = sync_q[SYNC_STAGES-1];
  assign s_next = sync_q[SYNC_STAGES-2];
  assign fall   = s & ~s_next;
  assign ack    = en_clk_i & int_executed_i;

  // Request vector, one-hot acknowledge and fixed-priority winner
  always_comb begin
    ext_req = '0;
    ack_vec = '0;
    win     = '0;
    for (int unsigned k = 0; k < NUM_EXT; k++) begin
      ext_req[k] = int_enable_q & mask_q[k] & (EDGE[k] ? edge_flag_q[k] : ~s[k]);
      ack_vec[k] = ack & (int_src_q == IDX_W'(k + 1));
    end
    for (int unsigned k = 0; k < NUM_EXT; k++) begin
      if (ext_req[NUM_EXT-1-k]) win = IDX_W'(NUM_EXT - k);
    end
  end

  assign any_req = (|ext_req) | tim_pend_q;

  // Edge flags: set on every clock, cleared only by an enabled acknowledge; set wins
  always_comb begin
    edge_flag_d = ((edge_flag_q & ~ack_vec) | fall) & EDGE;
  end

  // Enables, mask, timer flag/pending and arbitration latch, all gated by en_clk_i
  always_comb begin
    mask_d        = mask_q;
    int_enable_d  = int_enable_q;
    tim_en_d      = tim_en_q;
    tf_d          = tf_q;
    tim_pend_d    = tim_pend_q;
    in_progress_d = in_progress_q;
    int_src_d     = int_src_q;
    if (en_clk_i) begin
      if (mask_wr_i) mask_d = mask_i;
      if (dis_i_i) int_enable_d = 1'b0;
      else if (en_i_i) int_enable_d = 1'b1;
      if (dis_tcnti_i) tim_en_d = 1'b0;
      else if (en_tcnti_i) tim_en_d = 1'b1;
      if (jtf_executed_i) tf_d = 1'b0;
      else if (tim_overflow_i) tf_d = 1'b1;
      if (int_executed_i && (int_src_q == '0)) tim_pend_d = 1'b0;
      if (tim_overflow_i && tim_en_q) tim_pend_d = 1'b1;
      if (dis_tcnti_i || !tim_en_q) tim_pend_d = 1'b0;
      if (in_progress_q) begin
        if (retr_executed_i) in_progress_d = 1'b0;
      end else if (any_req) begin
        in_progress_d = 1'b1;
        int_src_d     = win;
      end
    end
  end

  // Service handshake state machine, next-state logic
  always_comb begin
    state_d = state_q;
    if (en_clk_i) begin
      case (state_q)
        IDLE:    if (in_progress_q && last_cycle_i && (clk_mstate_i == 3'd4)) state_d = PEND;
        PEND:    if (int_executed_i) state_d = ACTIVE;
        ACTIVE:  if (retr_executed_i) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Controller state registers
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      edge_flag_q   <= '0;
      mask_q        <= '1;
      int_enable_q  <= 1'b0;
      tim_en_q      <= 1'b0;
      tf_q          <= 1'b0;
      tim_pend_q    <= 1'b0;
      in_progress_q <= 1'b0;
      int_src_q     <= '0;
      state_q       <= IDLE;
    end else begin
      edge_flag_q   <= edge_flag_d;
      mask_q        <= mask_d;
      int_enable_q  <= int_enable_d;
      tim_en_q      <= tim_en_d;
      tf_q          <= tf_d;
      tim_pend_q    <= tim_pend_d;
      in_progress_q <= in_progress_d;
      int_src_q     <= int_src_d;
      state_q       <= state_d;
    end
  end

  // Service vector: timer 0x007, ext0 0x003, ext k>=1 at 0x003 + 4*(k+1)
  always_comb begin
    if (int_src_q == '0)                 int_vec_o = 12'h007;
    else if (int_src_q == IDX_W'(1))     int_vec_o = 12'h003;
    else                                 int_vec_o = 12'h003 + (12'(int_src_q) << 2);
  end

  assign tf_o              = tf_q;
  assign int_pending_o     = (state_q == PEND);
  assign int_in_progress_o = in_progress_q & (state_q != IDLE);
  assign int_src_o         = int_src_q;

endmodule

// File: tb/tb_t48_int_vec.sv
// Bench for t48_int_vec: directed vector table, hand-written corner-case
// sequences and a randomized run checked against a behavioural model.
module tb_t48_int_vec;

  localparam int          NE = 2;
  localparam int          SS = 2;
  localparam logic [6:0]  EM = 7'b0000010;   // ext0 level, ext1 falling edge

  localparam logic [8:0] ENI  = 9'h001, DISI = 9'h002, ENT  = 9'h004, DIST = 9'h008;
  localparam logic [8:0] OVF  = 9'h010, JTF  = 9'h020, EXE  = 9'h040, RETR = 9'h080;
  localparam logic [8:0] MWR  = 9'h100;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          en_clk = 1'b0;
  logic [2:0]    mstate = '0;
  logic          last_cycle = 1'b0;
  logic [NE-1:0] int_n = '1;
  logic          en_i = 1'b0, dis_i = 1'b0, en_t = 1'b0, dis_t = 1'b0;
  logic          ovf = 1'b0, jtf = 1'b0, exe = 1'b0, retr = 1'b0, mwr = 1'b0;
  logic [NE-1:0] mask = '1;
  logic          tf, pend, inprog;
  logic [2:0]    src;
  logic [11:0]   vec;

  int total = 0;
  int bad   = 0;

  t48_int_vec #(
    .NUM_EXT(NE),
    .EDGE_MASK(EM),
    .SYNC_STAGES(SS),
    .IDX_W(3)
  ) dut (
    .clk_i(clk),
    .res_i(res),
    .en_clk_i(en_clk),
    .clk_mstate_i(mstate),
    .last_cycle_i(last_cycle),
    .int_n_i(int_n),
    .en_i_i(en_i),
    .dis_i_i(dis_i),
    .en_tcnti_i(en_t),
    .dis_tcnti_i(dis_t),
    .tim_overflow_i(ovf),
    .jtf_executed_i(jtf),
    .int_executed_i(exe),
    .retr_executed_i(retr),
    .mask_wr_i(mwr),
    .mask_i(mask),
    .tf_o(tf),
    .int_pending_o(pend),
    .int_in_progress_o(inprog),
    .int_src_o(src),
    .int_vec_o(vec)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  logic [NE-1:0] m_hist[$];   // synchroniser contents, index 0 = output stage
  logic [NE-1:0] m_flag, m_mask;
  logic          m_ie, m_te, m_tf, m_tp, m_busy;
  int            m_src, m_st; // m_st: 0 idle, 1 call requested, 2 being serviced

  function automatic logic [11:0] ref_vec(int s);
    if (s == 0) return 12'h007;
    if (s == 1) return 12'h003;
    return 12'(3 + 4 * s);
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SS; i++) m_hist.push_back('1);
    m_flag = '0; m_mask = '1;
    m_ie = 0; m_te = 0; m_tf = 0; m_tp = 0; m_busy = 0;
    m_src = 0; m_st = 0;
  endtask

  task automatic model_step(input logic [8:0] c, input logic [NE-1:0] n, input logic e,
                            input logic l, input logic [2:0] ms, input logic [NE-1:0] mk);
    logic [NE-1:0] s, nx, nf;
    int win;
    logic ack;
    s   = m_hist[0];
    nx  = m_hist[1];
    ack = e && c[6];
    win = -1;
    for (int k = NE - 1; k >= 0; k--)
      if (m_ie && m_mask[k] && (EM[k] ? m_flag[k] : !s[k])) win = k + 1;
    if (win < 0 && m_tp) win = 0;
    nf = m_flag;
    for (int k = 0; k < NE; k++) begin
      if (EM[k]) begin
        if (ack && m_src == k + 1) nf[k] = 0;
        if (s[k] && !nx[k]) nf[k] = 1;
      end
    end
    m_flag = nf;
    if (e) begin
      int st;
      logic tp;
      st = m_st;
      if (m_st == 0 && m_busy && l && ms == 3'd4) st = 1;
      else if (m_st == 1 && c[6]) st = 2;
      else if (m_st == 2 && c[7]) st = 0;
      tp = m_tp;
      if (c[6] && m_src == 0) tp = 0;
      if (c[4] && m_te) tp = 1;
      if (c[3] || !m_te) tp = 0;
      if (m_busy) begin
        if (c[7]) m_busy = 0;
      end else if (win >= 0) begin
        m_busy = 1;
        m_src  = win;
      end
      m_st = st;
      m_tp = tp;
      if (c[8]) m_mask = mk;
      if (c[1]) m_ie = 0; else if (c[0]) m_ie = 1;
      if (c[3]) m_te = 0; else if (c[2]) m_te = 1;
      if (c[5]) m_tf = 0; else if (c[4]) m_tf = 1;
    end
    void'(m_hist.pop_front());
    m_hist.push_back(n);
  endtask

  // ---------------- drive / check helpers ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_out(input string nm, input logic etf, input logic epd, input logic eip,
                           input logic [2:0] esrc, input logic [11:0] evec);
    chk({nm, ".tf"}, 32'(tf), 32'(etf));
    chk({nm, ".pend"}, 32'(pend), 32'(epd));
    chk({nm, ".inprog"}, 32'(inprog), 32'(eip));
    chk({nm, ".src"}, 32'(src), 32'(esrc));
    chk({nm, ".vec"}, 32'(vec), 32'(evec));
  endtask

  task automatic drive(input logic [8:0] c, input logic [NE-1:0] n, input logic e = 1'b1,
                       input logic l = 1'b0, input logic [2:0] ms = 3'd0,
                       input logic [NE-1:0] mk = '1);
    @(negedge clk);
    {mwr, retr, exe, jtf, ovf, dis_t, en_t, dis_i, en_i} = c;
    int_n = n; en_clk = e; last_cycle = l; mstate = ms; mask = mk;
    model_step(c, n, e, l, ms, mk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [8:0]    c;
    logic [NE-1:0] n;
    logic          e, l;
    logic [2:0]    ms;
    logic [NE-1:0] mk;
    logic          tf, pd, ip;
    logic [2:0]    src;
    logic [11:0]   vec;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic [8:0] c, logic [NE-1:0] n, logic e, logic l, logic [2:0] ms,
                              logic [NE-1:0] mk, logic t, logic p, logic ip, logic [2:0] s,
                              logic [11:0] v);
    vec_t r;
    r.c = c; r.n = n; r.e = e; r.l = l; r.ms = ms; r.mk = mk;
    r.tf = t; r.pd = p; r.ip = ip; r.src = s; r.vec = v;
    tbl.push_back(r);
  endfunction

  initial begin
    // single level ext0 service
    add(ENI,       2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 0, 12'h007);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 0, 12'h007);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 0, 12'h007);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 1, 4, 2'b11, 0, 1, 1, 1, 12'h003);
    add(EXE,       2'b11, 1, 0, 0, 2'b11, 0, 0, 1, 1, 12'h003);
    add(0,         2'b11, 1, 0, 0, 2'b11, 0, 0, 1, 1, 12'h003);
    add(RETR,      2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    // masked ext0 stays silent, unmasking lets it through
    add(MWR,       2'b10, 1, 0, 0, 2'b10, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 1, 4, 2'b11, 0, 0, 0, 1, 12'h003);
    add(MWR,       2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b11, 1, 1, 4, 2'b11, 0, 1, 1, 1, 12'h003);
    add(EXE,       2'b11, 1, 0, 0, 2'b11, 0, 0, 1, 1, 12'h003);
    add(RETR,      2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    // DIS I wins over a simultaneous EN I
    add(DISI,      2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(ENI|DISI,  2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b10, 1, 1, 4, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    // timer flag: clear wins, and updates need en_clk_i
    add(OVF,       2'b11, 1, 0, 0, 2'b11, 1, 0, 0, 1, 12'h003);
    add(OVF|JTF,   2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(OVF,       2'b11, 0, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
    add(0,         2'b11, 1, 0, 0, 2'b11, 0, 0, 0, 1, 12'h003);
  end

  // ---------------- main sequence ----------------
  initial begin
    #1;
    // reset held: outputs stay at reset values while int_n toggles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      int_n = NE'($urandom);
      @(posedge clk);
      #1;
      check_out($sformatf("rst%0d", i), 0, 0, 0, 0, 12'h007);
    end
    @(negedge clk);
    res = 1'b1; int_n = '1; en_clk = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].c, tbl[i].n, tbl[i].e, tbl[i].l, tbl[i].ms, tbl[i].mk);
      check_out($sformatf("tbl%0d", i), tbl[i].tf, tbl[i].pd, tbl[i].ip, tbl[i].src, tbl[i].vec);
    end

    // priority: ext0 level, ext1 edge and timer all pending together
    drive(ENI|ENT, 2'b11);        check_out("pri_en", 0, 0, 0, 1, 12'h003);
    drive(OVF, 2'b01);            check_out("pri_ovf", 1, 0, 0, 1, 12'h003);
    drive(0, 2'b00, 0);
    drive(0, 2'b00, 0);
    drive(0, 2'b00, 1);           check_out("pri_arb0", 1, 0, 0, 1, 12'h003);
    drive(0, 2'b00, 1, 1, 4);     check_out("pri_pend0", 1, 1, 1, 1, 12'h003);
    drive(EXE, 2'b01);            check_out("pri_exe0", 1, 0, 1, 1, 12'h003);
    drive(0, 2'b01);
    drive(RETR, 2'b01);           check_out("pri_retr0", 1, 0, 0, 1, 12'h003);
    drive(0, 2'b01);              check_out("pri_arb1", 1, 0, 0, 2, 12'h00B);
    drive(0, 2'b01, 1, 1, 4);     check_out("pri_pend1", 1, 1, 1, 2, 12'h00B);
    drive(EXE, 2'b01);            check_out("pri_exe1", 1, 0, 1, 2, 12'h00B);
    drive(RETR, 2'b01);           check_out("pri_retr1", 1, 0, 0, 2, 12'h00B);
    drive(0, 2'b11);              check_out("pri_arbt", 1, 0, 0, 0, 12'h007);
    drive(0, 2'b11, 1, 1, 4);     check_out("pri_pendt", 1, 1, 1, 0, 12'h007);
    drive(EXE, 2'b11);            check_out("pri_exet", 1, 0, 1, 0, 12'h007);
    drive(RETR, 2'b11);           check_out("pri_retrt", 1, 0, 0, 0, 12'h007);
    drive(0, 2'b11);
    drive(0, 2'b11, 1, 1, 4);     check_out("pri_quiet", 1, 0, 0, 0, 12'h007);
    drive(JTF, 2'b11);            check_out("pri_jtf", 0, 0, 0, 0, 12'h007);

    // edge captured while en_clk_i is low; new edge in the acknowledge cycle re-arms
    drive(0, 2'b01, 0);
    drive(0, 2'b11, 0);
    drive(0, 2'b11, 0);
    drive(0, 2'b11, 1);           check_out("edg_arb", 0, 0, 0, 2, 12'h00B);
    drive(0, 2'b01, 1, 1, 4);     check_out("edg_pend", 0, 1, 1, 2, 12'h00B);
    drive(EXE, 2'b11);            check_out("edg_exe", 0, 0, 1, 2, 12'h00B);
    drive(RETR, 2'b11);           check_out("edg_retr", 0, 0, 0, 2, 12'h00B);
    drive(0, 2'b11);
    drive(0, 2'b11, 1, 1, 4);     check_out("edg_reserve", 0, 1, 1, 2, 12'h00B);
    drive(EXE, 2'b11);            check_out("edg_exe2", 0, 0, 1, 2, 12'h00B);
    drive(RETR, 2'b11);
    drive(0, 2'b11);
    drive(0, 2'b11, 1, 1, 4);     check_out("edg_cleared", 0, 0, 0, 2, 12'h00B);

    // asynchronous reset in the middle of a service
    drive(0, 2'b10);
    drive(0, 2'b10);
    drive(OVF, 2'b10);            check_out("mid_arb", 1, 0, 0, 1, 12'h003);
    drive(0, 2'b10, 1, 1, 4);     check_out("mid_pend", 1, 1, 1, 1, 12'h003);
    drive(EXE, 2'b10);            check_out("mid_active", 1, 0, 1, 1, 12'h003);
    #2 res = 1'b0;
    #1 check_out("mid_rst_now", 0, 0, 0, 0, 12'h007);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      int_n = NE'($urandom);
      @(posedge clk);
      #1;
      check_out($sformatf("mid_rst%0d", i), 0, 0, 0, 0, 12'h007);
    end
    @(negedge clk);
    {mwr, retr, exe, jtf, ovf, dis_t, en_t, dis_i, en_i} = '0;
    int_n = '1; en_clk = 1'b1; last_cycle = 1'b0; mstate = '0; mask = '1;
    res = 1'b1;
    model_reset();

    // randomized run against the reference model
    begin
      logic [NE-1:0] n;
      n = '1;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        logic [8:0] c;
        c = '0;
        for (int b = 0; b < 9; b++) if ($urandom_range(0, 7) == 0) c[b] = 1'b1;
        if ($urandom_range(0, 3) != 0) c[1] = 1'b0;
        if ($urandom_range(0, 3) != 0) c[3] = 1'b0;
        if ($urandom_range(0, 2) == 0) n = n ^ NE'($urandom_range(1, 3));
        drive(c, n, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              ($urandom_range(0, 1) != 0) ? 3'd4 : 3'($urandom_range(0, 7)), NE'($urandom));
        check_out($sformatf("rnd%0d", cyc), m_tf, m_st == 1, m_busy && m_st != 0,
                  3'(m_src), ref_vec(m_src));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
